axis_pattern_gen: RTL and testbench

AXI4-Stream video test-pattern transmitter, one clock domain. Produces complete frames of 8-bit pixels with start-of-frame and end-of-line markers, obeys downstream `m_axis_tready` backpressure, and inserts programmable horizontal and vertical blanking. It is the stimulus source at the head of the pixel pipeline and drives stream consumers such as the gain stage.

---
 rtl/axis_pattern_gen.sv | 210 +++++++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// Purpose: AXI4-Stream video test-pattern source (ramps, checkerboard, constant) with SOF/EOL and blanking.
// Latency: enable sampled at edge N latches config; first beat valid after edge N+1.
// Backpressure: beat outputs hold while tvalid & !tready; the next beat loads only on handshake.
// Ports: clk/rst (sync, active-high); enable + frame config in; m_axis_* stream out;
//        frame_done pulses once per frame; busy is high outside IDLE.
// Option: PATTERN_GEN_FRAME_CNT_EN adds frame_cnt[15:0] and offsets the horizontal ramp by it.
module axis_pattern_gen #(
  parameter int PPC         = 1,
  parameter int TUSER_WIDTH = 5,
  parameter int TDEST_WIDTH = 2,
  parameter int TDATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [12:0]                frame_width,
  input  logic [11:0]                frame_height,
  input  logic [7:0]                 hblank,
  input  logic [11:0]                vblank,
  input  logic [1:0]                 pattern_sel,
  input  logic [TDATA_WIDTH-1:0]     const_val,
  input  logic [TDEST_WIDTH-1:0]     tdest_cfg,
  output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [PPC*TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                       frame_done,
`ifdef PATTERN_GEN_FRAME_CNT_EN
  output logic [15:0]                frame_cnt,
`endif
  output logic                       busy
);

  localparam int DW = PPC * TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          sof;
  } beat_t;

  state_t                 state;
  logic [12:0]            x_q;
  logic [11:0]            y_q;
  logic [11:0]            blank_cnt;
  logic [12:0]            width_q;
  logic [11:0]            height_q;
  logic [7:0]             hblank_q;
  logic [11:0]            vblank_q;
  logic [1:0]             pat_q;
  logic [TDATA_WIDTH-1:0] const_q;
  logic [TDEST_WIDTH-1:0] tdest_q;
  logic                   tvalid_q;
  logic                   done_q;
  logic                   busy_q;
  beat_t                  beat_q;
  beat_t                  beat_cur;
  beat_t                  beat_adv;
  beat_t                  beat_nl;
  logic [7:0]             ramp_ofs;

`ifdef PATTERN_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign ramp_ofs  = frame_cnt_q[7:0];
`else
  assign ramp_ofs  = 8'd0;
`endif

  function automatic logic [TDATA_WIDTH-1:0] pixel(input logic [7:0] px8, input logic [7:0] py8);
    logic [7:0] v8;
    case (pat_q)
      2'd0:    v8 = px8 + ramp_ofs;
      2'd1:    v8 = py8;
      default: v8 = (px8[3] ^ py8[3]) ? 8'hFF : 8'h00;
    endcase
    return (pat_q == 2'd3) ? const_q : TDATA_WIDTH'(v8);
  endfunction

  // Lanes past the end of the line are zero; tlast marks the beat that reaches the width.
  function automatic beat_t make_beat(input logic [13:0] bx, input logic [11:0] by);
    beat_t      b;
    logic [13:0] px;
    b = '0;
    for (int k = 0; k < PPC; k++) begin
      px = bx + 14'(k);
      if (px < {1'b0, width_q})
        b.data[k*TDATA_WIDTH +: TDATA_WIDTH] = pixel(px[7:0], by[7:0]);
    end
    b.last = (bx + 14'(PPC)) >= {1'b0, width_q};
    b.sof  = (bx == 14'd0) && (by == 12'd0);
    return b;
  endfunction

  // Candidate beats: current position, next beat on the line, first beat of the next line.
  always_comb begin
    beat_cur = make_beat({1'b0, x_q}, y_q);
    beat_adv = make_beat({1'b0, x_q} + 14'(PPC), y_q);
    beat_nl  = make_beat(14'd0, y_q + 12'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      blank_cnt <= '0;
      width_q   <= '0;
      height_q  <= '0;
      hblank_q  <= '0;
      vblank_q  <= '0;
      pat_q     <= '0;
      const_q   <= '0;
      tdest_q   <= '0;
      tvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      beat_q    <= '0;
`ifdef PATTERN_GEN_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && frame_width != 13'd0 && frame_height != 12'd0) begin
            width_q  <= frame_width;
            height_q <= frame_height;
            hblank_q <= hblank;
            vblank_q <= vblank;
            pat_q    <= pattern_sel;
            const_q  <= const_val;
            tdest_q  <= tdest_cfg;
            x_q      <= '0;
            y_q      <= '0;
            state    <= ACTIVE;
            busy_q   <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!tvalid_q) begin
            // Only reached on the cycle right after a frame is accepted.
            beat_q   <= beat_cur;
            tvalid_q <= 1'b1;
          end else if (m_axis_tready) begin
            if (!beat_q.last) begin
              x_q    <= x_q + 13'(PPC);
              beat_q <= beat_adv;
            end else if (y_q != height_q - 12'd1) begin
              x_q <= '0;
              y_q <= y_q + 12'd1;
              if (hblank_q == 8'd0) begin
                beat_q <= beat_nl;
              end else begin
                tvalid_q  <= 1'b0;
                blank_cnt <= '0;
                state     <= HBLANK;
              end
            end else begin
              tvalid_q <= 1'b0;
              done_q   <= 1'b1;
`ifdef PATTERN_GEN_FRAME_CNT_EN
              frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
              if (vblank_q == 12'd0) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                blank_cnt <= '0;
                state     <= VBLANK;
              end
            end
          end
        end
        HBLANK: begin
          // The first beat of the line loads on the last blank cycle so the gap is exactly hblank.
          if (blank_cnt == {4'd0, hblank_q} - 12'd1) begin
            beat_q   <= beat_cur;
            tvalid_q <= 1'b1;
            state    <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt + 12'd1;
          end
        end
        VBLANK: begin
          if (blank_cnt == vblank_q - 12'd1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tlast  = beat_q.last;
  assign m_axis_tuser  = TUSER_WIDTH'(beat_q.sof);
  assign m_axis_tdest  = tdest_q;
  assign frame_done    = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en1 = 1'b0;
  logic        en2 = 1'b0;
  logic [12:0] frame_width = '0;
  logic [11:0] frame_height = '0;
  logic [7:0]  hblank = '0;
  logic [11:0] vblank = '0;
  logic [1:0]  pattern_sel = '0;
  logic [7:0]  const_val = '0;
  logic [1:0]  tdest_cfg = '0;
  logic        tready = 1'b1;

  logic [4:0]  tuser1, tuser2;
  logic [1:0]  tdest1, tdest2;
  logic        tvalid1, tvalid2, tlast1, tlast2, done1, done2, busy1, busy2;
  logic [7:0]  tdata1;
  logic [15:0] tdata2;

  always #5 clk = ~clk;

  axis_pattern_gen #(.PPC(1)) dut (
    .clk(clk), .rst(rst), .enable(en1),
    .frame_width(frame_width), .frame_height(frame_height),
    .hblank(hblank), .vblank(vblank), .pattern_sel(pattern_sel),
    .const_val(const_val), .tdest_cfg(tdest_cfg),
    .m_axis_tuser(tuser1), .m_axis_tdest(tdest1), .m_axis_tvalid(tvalid1),
    .m_axis_tready(tready), .m_axis_tlast(tlast1), .m_axis_tdata(tdata1),
    .frame_done(done1), .busy(busy1)
  );

  axis_pattern_gen #(.PPC(2)) dut2 (
    .clk(clk), .rst(rst), .enable(en2),
    .frame_width(frame_width), .frame_height(frame_height),
    .hblank(hblank), .vblank(vblank), .pattern_sel(pattern_sel),
    .const_val(const_val), .tdest_cfg(tdest_cfg),
    .m_axis_tuser(tuser2), .m_axis_tdest(tdest2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready), .m_axis_tlast(tlast2), .m_axis_tdata(tdata2),
    .frame_done(done2), .busy(busy2)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] cap_data[$];
  logic        cap_last[$];
  logic [4:0]  cap_user[$];
  logic [1:0]  cap_dest[$];
  int          cap_cyc[$];
  int          done_cyc[$];
  int          busy_fall;
  int          stall_viol;
  int          stall_seen;
  bit [3:0]    bp_pat = 4'b1001;

  task automatic do_reset;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Records accepted beats for a fixed number of cycles; enable drops after the latch edge.
  task automatic capture(input int ncyc, input bit sel, input bit bp, input bit scramble);
    logic v, l, fd, bz, pv, pr, pl;
    logic [15:0] d, pd;
    logic [4:0]  u, pu;
    logic [1:0]  td;
    bit seen_busy;
    cap_data.delete(); cap_last.delete(); cap_user.delete();
    cap_dest.delete(); cap_cyc.delete(); done_cyc.delete();
    busy_fall = -1; stall_viol = 0; stall_seen = 0; seen_busy = 0;
    pv = 0; pr = 1; pd = '0; pl = 0; pu = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        en1 = 1'b0; en2 = 1'b0;
        if (scramble) begin
          pattern_sel = 2'd3; const_val = 8'h77; frame_width = 13'd3; frame_height = 12'd1;
          tdest_cfg = 2'd0;
        end
      end
      if (sel) begin
        v = tvalid2; l = tlast2; fd = done2; bz = busy2; d = tdata2; u = tuser2; td = tdest2;
      end else begin
        v = tvalid1; l = tlast1; fd = done1; bz = busy1; d = {8'h00, tdata1}; u = tuser1; td = tdest1;
      end
      tready = bp ? bp_pat[c % 4] : 1'b1;
      if (pv && !pr) begin
        stall_seen++;
        if (!v || d !== pd || l !== pl || u !== pu) stall_viol++;
      end
      if (fd) done_cyc.push_back(c);
      if (bz) seen_busy = 1;
      else if (seen_busy && busy_fall < 0) busy_fall = c;
      if (v && tready) begin
        cap_data.push_back(d); cap_last.push_back(l); cap_user.push_back(u);
        cap_dest.push_back(td); cap_cyc.push_back(c);
      end
      pv = v; pr = tready; pd = d; pl = l; pu = u;
    end
    tready = 1'b1;
  endtask

  task automatic test_reset;
    frame_width = 13'd7; frame_height = 12'd3; tdest_cfg = 2'd3; const_val = 8'hA5;
    rst = 1'b1; en1 = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    n_chk++; if (tvalid1 !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", tvalid1); else n_pass++;
    n_chk++; if (tlast1 !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", tlast1); else n_pass++;
    n_chk++; if (tuser1 !== 5'd0) $display("FAIL rst_tuser: got %0h expected 0", tuser1); else n_pass++;
    n_chk++; if (tdest1 !== 2'd0) $display("FAIL rst_tdest: got %0h expected 0", tdest1); else n_pass++;
    n_chk++; if (tdata1 !== 8'd0) $display("FAIL rst_tdata: got %0h expected 0", tdata1); else n_pass++;
    n_chk++; if (done1 !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", done1); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy1); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_zero_size;
    int bad;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      frame_width = (t == 0) ? 13'd0 : 13'd4;
      frame_height = (t == 0) ? 12'd2 : 12'd0;
      en1 = 1'b1; bad = 0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (busy1 || tvalid1) bad++;
      end
      en1 = 1'b0;
      n_chk++; if (bad !== 0) $display("FAIL zero_size_%0d: active cycles %0d expected 0", t, bad); else n_pass++;
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    logic [7:0] exp_last = 8'h88;
    logic [15:0] gd; logic gl; logic [4:0] gu; logic [1:0] gt;
    do_reset();
    frame_width = 13'd4; frame_height = 12'd2; hblank = 8'd0; vblank = 12'd0;
    pattern_sel = 2'd0; tdest_cfg = 2'd2; en1 = 1'b1;
    capture(20, 1'b0, 1'b0, 1'b0);
    n_chk++; if (cap_data.size() !== 8) $display("FAIL basic_beats: got %0d expected 8", cap_data.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      gd = (i < cap_data.size()) ? cap_data[i] : 16'hFFFF;
      gl = (i < cap_last.size()) ? cap_last[i] : 1'bx;
      gu = (i < cap_user.size()) ? cap_user[i] : 5'h1F;
      gt = (i < cap_dest.size()) ? cap_dest[i] : 2'bxx;
      n_chk++;
      if ({gd, gl, gu, gt} !== {8'h00, exp_d[i], exp_last[i], 5'(i == 0), 2'd2})
        $display("FAIL basic_beat%0d: got d=%0h l=%b u=%0h t=%0h expected d=%0h l=%b u=%0h t=2",
                 i, gd, gl, gu, gt, exp_d[i], exp_last[i], 5'(i == 0));
      else n_pass++;
    end
    n_chk++;
    if (cap_cyc.size() != 8 || cap_cyc[7] - cap_cyc[0] != 7)
      $display("FAIL basic_no_gap: beats %0d not in 8 consecutive cycles", cap_cyc.size());
    else n_pass++;
    n_chk++;
    if (done_cyc.size() != 1 || cap_cyc.size() != 8 || done_cyc[0] != cap_cyc[7] + 1)
      $display("FAIL basic_done: pulses %0d at %0d expected 1 at %0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, (cap_cyc.size() == 8) ? cap_cyc[7] + 1 : -1);
    else n_pass++;
    n_chk++; if (busy_fall !== 9) $display("FAIL basic_busy_fall: got %0d expected 9", busy_fall); else n_pass++;
  endtask

  task automatic test_ppc2;
    logic [15:0] exp_d [3] = '{16'h0100, 16'h0302, 16'h0004};
    logic [2:0]  exp_last = 3'b100;
    logic [15:0] gd; logic gl;
    do_reset();
    frame_width = 13'd5; frame_height = 12'd1; hblank = 8'd0; vblank = 12'd0;
    pattern_sel = 2'd0; tdest_cfg = 2'd1; en2 = 1'b1;
    capture(12, 1'b1, 1'b0, 1'b0);
    n_chk++; if (cap_data.size() !== 3) $display("FAIL ppc2_beats: got %0d expected 3", cap_data.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      gd = (i < cap_data.size()) ? cap_data[i] : 16'hFFFF;
      gl = (i < cap_last.size()) ? cap_last[i] : 1'bx;
      n_chk++;
      if ({gd, gl} !== {exp_d[i], exp_last[i]})
        $display("FAIL ppc2_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, gd, gl, exp_d[i], exp_last[i]);
      else n_pass++;
    end
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL ppc2_done: got %0d pulses expected 1", done_cyc.size()); else n_pass++;
  endtask

  task automatic test_patterns;
    logic [7:0] exp_v [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    logic [15:0] gd, ed;
    int bad, nlast, x, y;
    // vertical ramp
    do_reset();
    frame_width = 13'd2; frame_height = 12'd3; hblank = 8'd0; vblank = 12'd0;
    pattern_sel = 2'd1; en1 = 1'b1;
    capture(12, 1'b0, 1'b0, 1'b0);
    n_chk++; if (cap_data.size() !== 6) $display("FAIL vramp_beats: got %0d expected 6", cap_data.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      gd = (i < cap_data.size()) ? cap_data[i] : 16'hFFFF;
      n_chk++; if (gd !== {8'h00, exp_v[i]}) $display("FAIL vramp_beat%0d: got %0h expected %0h", i, gd, exp_v[i]); else n_pass++;
    end
    // checkerboard under backpressure, with config scrambled after the frame starts
    do_reset();
    frame_width = 13'd16; frame_height = 12'd9; hblank = 8'd2; vblank = 12'd1;
    pattern_sel = 2'd2; tdest_cfg = 2'd3; en1 = 1'b1;
    capture(450, 1'b0, 1'b1, 1'b1);
    n_chk++; if (cap_data.size() !== 144) $display("FAIL chk_beats: got %0d expected 144", cap_data.size()); else n_pass++;
    bad = 0; nlast = 0;
    for (int i = 0; i < cap_data.size() && i < 144; i++) begin
      x = i % 16; y = i / 16;
      ed = ((x / 8 + y / 8) % 2 == 1) ? 16'h00FF : 16'h0000;
      if (cap_data[i] !== ed || cap_last[i] !== (x == 15) || cap_dest[i] !== 2'd3) bad++;
      if (cap_last[i]) nlast++;
    end
    n_chk++; if (bad !== 0) $display("FAIL chk_values: got %0d bad beats expected 0", bad); else n_pass++;
    n_chk++; if (nlast !== 9) $display("FAIL chk_tlast_count: got %0d expected 9", nlast); else n_pass++;
    n_chk++; if (stall_seen == 0) $display("FAIL bp_stalls: got %0d stall cycles expected >0", stall_seen); else n_pass++;
    n_chk++; if (stall_viol !== 0) $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_viol); else n_pass++;
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL chk_done: got %0d pulses expected 1", done_cyc.size()); else n_pass++;
  endtask

  task automatic test_blanking;
    do_reset();
    frame_width = 13'd2; frame_height = 12'd2; hblank = 8'd3; vblank = 12'd5;
    pattern_sel = 2'd0; en1 = 1'b1;
    capture(25, 1'b0, 1'b0, 1'b0);
    n_chk++; if (cap_cyc.size() !== 4) $display("FAIL blank_beats: got %0d expected 4", cap_cyc.size()); else n_pass++;
    if (cap_cyc.size() == 4) begin
      n_chk++;
      if (cap_cyc[2] - cap_cyc[1] - 1 !== 3) $display("FAIL hblank_gap: got %0d expected 3", cap_cyc[2] - cap_cyc[1] - 1);
      else n_pass++;
      n_chk++;
      if (busy_fall - cap_cyc[3] - 1 !== 5) $display("FAIL vblank_gap: got %0d expected 5", busy_fall - cap_cyc[3] - 1);
      else n_pass++;
      n_chk++;
      if (busy_fall - cap_cyc[0] !== 12) $display("FAIL frame_span: got %0d expected 12", busy_fall - cap_cyc[0]);
      else n_pass++;
    end
    n_chk++;
    if (done_cyc.size() != 1 || done_cyc[0] != 8)
      $display("FAIL blank_done: got %0d pulses first at %0d expected 1 at 8", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else n_pass++;
  endtask

  task automatic test_enable_pulse;
    int bad;
    do_reset();
    frame_width = 13'd3; frame_height = 12'd2; hblank = 8'd1; vblank = 12'd2;
    pattern_sel = 2'd3; const_val = 8'h5A; tdest_cfg = 2'd1; en1 = 1'b1;
    capture(30, 1'b0, 1'b0, 1'b0);
    n_chk++; if (cap_data.size() !== 6) $display("FAIL pulse_beats: got %0d expected 6", cap_data.size()); else n_pass++;
    bad = 0;
    foreach (cap_data[i]) if (cap_data[i] !== 16'h005A) bad++;
    n_chk++; if (bad !== 0) $display("FAIL pulse_const: got %0d bad beats expected 0", bad); else n_pass++;
    n_chk++; if (done_cyc.size() !== 1) $display("FAIL pulse_done: got %0d pulses expected 1", done_cyc.size()); else n_pass++;
    n_chk++; if (busy_fall !== 10) $display("FAIL pulse_busy_fall: got %0d expected 10", busy_fall); else n_pass++;
    n_chk++; if (busy1 !== 1'b0) $display("FAIL pulse_idle_end: got busy %b expected 0", busy1); else n_pass++;
  endtask

  task automatic test_rst_midline;
    do_reset();
    frame_width = 13'd8; frame_height = 12'd2; hblank = 8'd0; vblank = 12'd0;
    pattern_sel = 2'd0; en1 = 1'b1; tready = 1'b1;
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1; end
    n_chk++;
    if ({tvalid1, tdata1} !== {1'b1, 8'd2}) $display("FAIL midline_pre: got v=%b d=%0h expected v=1 d=2", tvalid1, tdata1);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if (tvalid1 !== 1'b0) $display("FAIL rst_abort_tvalid: got %b expected 0", tvalid1); else n_pass++;
    n_chk++; if ({done1, busy1} !== 2'b00) $display("FAIL rst_abort_done_busy: got %b expected 00", {done1, busy1}); else n_pass++;
    @(posedge clk); #1;
    en1 = 1'b0;
    n_chk++; if ({busy1, tvalid1, done1} !== 3'b100) $display("FAIL restart_latch: got %b expected 100", {busy1, tvalid1, done1}); else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({tvalid1, tuser1, tdata1} !== {1'b1, 5'd1, 8'd0})
      $display("FAIL restart_sof: got v=%b u=%0h d=%0h expected v=1 u=1 d=0", tvalid1, tuser1, tdata1);
    else n_pass++;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_zero_size();
    test_basic();
    test_ppc2();
    test_patterns();
    test_blanking();
    test_enable_pulse();
    test_rst_midline();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
